// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack into a 2-entry prefetch buffer, redirects on taken branches.
// Optional perf counters (perf_fetched, perf_stall) are built when FETCH_PERF_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        advance,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus8
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam logic [1:0]  FULL          = 2'(DEPTH);
   localparam logic [31:0] RESET_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic {S_FETCH, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] e0_pc_q, e0_pc_d, e0_dat_q, e0_dat_d;
   logic [31:0] e1_pc_q, e1_pc_d, e1_dat_q, e1_dat_d;

   logic        req_raw;
   logic        pop;
   logic        redirect;
   logic        xfer;
   logic        push;
   logic [1:0]  slot;
   logic [31:0] target;

   assign instr_valid = (count_q != 2'd0);
   assign pop         = advance & instr_valid;
   assign redirect    = pop & pc_src;
   assign target      = {branch_target[31:2], 2'b00};

   // A full buffer may still request when the head retires this cycle.
   assign req_raw   = (state_q == S_DROP) ? 1'b1
                    : ((count_q < FULL) | ((count_q == FULL) & advance));
   assign imem_req  = req_raw & ~reset;
   assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

   assign xfer = imem_req & imem_ack;
   assign push = xfer & (state_q == S_FETCH) & ~redirect;
   assign slot = count_q - 2'(pop);

   assign instr    = e0_dat_q;
   assign instr_pc = e0_pc_q;
   assign pc_plus8 = e0_pc_q + 32'd8;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      count_d     = count_q;
      e0_pc_d     = e0_pc_q;
      e0_dat_d    = e0_dat_q;
      e1_pc_d     = e1_pc_q;
      e1_dat_d    = e1_dat_q;

      if ((state_q == S_DROP) && xfer) begin
         state_d = S_FETCH;
      end

      if (redirect) begin
         count_d    = 2'd0;
         fetch_pc_d = target;
         // An in-flight request must still complete; its word is thrown away.
         if ((state_q == S_FETCH) && imem_req && !imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = fetch_pc_q;
         end
      end else begin
         // Entry data is only moved, never cleared, so the outputs hold when empty.
         if (pop && (count_q == 2'd2)) begin
            e0_pc_d  = e1_pc_q;
            e0_dat_d = e1_dat_q;
         end
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (slot == 2'd0) begin
               e0_pc_d  = fetch_pc_q;
               e0_dat_d = imem_rdata;
            end else begin
               e1_pc_d  = fetch_pc_q;
               e1_dat_d = imem_rdata;
            end
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         fetch_pc_q  <= RESET_ALIGNED;
         drop_addr_q <= RESET_ALIGNED;
         count_q     <= 2'd0;
         e0_pc_q     <= 32'd0;
         e0_dat_q    <= 32'd0;
         e1_pc_q     <= 32'd0;
         e1_dat_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
         count_q     <= count_d;
         e0_pc_q     <= e0_pc_d;
         e0_dat_q    <= e0_dat_d;
         e1_pc_q     <= e1_pc_d;
         e1_dat_q    <= e1_dat_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= 32'd0;
         perf_stall_q   <= 32'd0;
      end else begin
         if (push) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (!instr_valid) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, multi-cycle corner sequences, random traffic vs a queue model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        advance, pc_src;
   logic [31:0] branch_target;
   logic [31:0] instr, instr_pc, pc_plus8;
   logic        instr_valid;

   bit          zw;
   logic        ack_drv;
   logic [31:0] key;

   logic        req2, ack2, vld2;
   logic [31:0] addr2, rdata2, instr2, ipc2, p8_2;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

   assign imem_ack   = imem_req & (zw | ack_drv);
   assign imem_rdata = imem_addr ^ key;
   assign ack2       = req2;
   assign rdata2     = addr2;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .advance(advance), .pc_src(pc_src), .branch_target(branch_target),
      .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus8(pc_plus8)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
      .advance(1'b1), .pc_src(1'b0), .branch_target(32'h0),
      .instr(instr2), .instr_valid(vld2), .instr_pc(ipc2), .pc_plus8(p8_2)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: the buffer is a plain queue of {pc, word}.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] dat;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fpc, m_drop_addr, m_last_pc, m_last_dat;
   bit          m_drop;
   int unsigned m_fetched, m_stall;

   task automatic model_reset();
      mq.delete();
      m_fpc       = 32'h0;
      m_drop_addr = 32'h0;
      m_drop      = 1'b0;
      m_last_pc   = 32'h0;
      m_last_dat  = 32'h0;
      m_fetched   = 0;
      m_stall     = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'h0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_vld"}, 32'(instr_valid), 32'h0);
      chk({tag, "_pc"}, instr_pc, 32'h0);
      chk({tag, "_p8"}, pc_plus8, 32'h8);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf_f"}, perf_fetched, 32'h0);
      chk({tag, "_perf_s"}, perf_stall, 32'h0);
`endif
   endtask

   // Called at a falling edge; leaves reset released at a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      advance = 1'b0;
      pc_src = 1'b0;
      branch_target = 32'h0;
      ack_drv = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
   endtask

   // One clock of main-DUT traffic, checked against the model.
   task automatic cycle(input bit adv, input bit src, input logic [31:0] tgt, input bit ack);
      bit          exp_req, ack_eff, pop, redir;
      logic [31:0] exp_addr;
      advance = adv;
      pc_src = src;
      branch_target = tgt;
      ack_drv = ack;
      #1;
      exp_req  = m_drop || (mq.size() < 2) || (mq.size() == 2 && adv);
      exp_addr = m_drop ? m_drop_addr : m_fpc;
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("addr", imem_addr, exp_addr);
      ack_eff = exp_req && (zw || ack);
      pop     = adv && (mq.size() > 0);
      redir   = pop && src;
      if (mq.size() == 0) m_stall++;
      if (redir) begin
         mq.delete();
         if (m_drop) begin
            if (ack_eff) m_drop = 1'b0;
         end else if (exp_req && !ack_eff) begin
            m_drop = 1'b1;
            m_drop_addr = m_fpc;
         end
         m_fpc = {tgt[31:2], 2'b00};
      end else begin
         if (pop) void'(mq.pop_front());
         if (ack_eff) begin
            if (m_drop) m_drop = 1'b0;
            else begin
               mq.push_back('{exp_addr, exp_addr ^ key});
               m_fpc = m_fpc + 32'd4;
               m_fetched++;
            end
         end
      end
      if (mq.size() > 0) begin
         m_last_pc  = mq[0].pc;
         m_last_dat = mq[0].dat;
      end
      @(posedge clk);
      @(negedge clk);
      chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
      chk("instr", instr, m_last_dat);
      chk("instr_pc", instr_pc, m_last_pc);
      chk("pc_plus8", pc_plus8, m_last_pc + 32'd8);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(m_fetched));
      chk("perf_stall", perf_stall, 32'(m_stall));
`endif
   endtask

   // Fill two entries over a 3-cycle memory, then redirect while the fetch of 0x8 is pending.
   task automatic seq_to_drop();
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 1);
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 1);
      cycle(1, 0, 32'h0, 0);
      cycle(1, 1, 32'h103, 0);
   endtask

   typedef struct {
      bit          adv;
      bit          req;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] pc;
   } vec_t;

   vec_t tv[7];

   initial begin
      tv[0] = '{1'b0, 1'b1, 32'h0, 1'b1, 32'h0};
      tv[1] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
      tv[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
      tv[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
      tv[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
      tv[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
      tv[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

      reset = 1'b1;
      advance = 1'b0;
      pc_src = 1'b0;
      branch_target = 32'h0;
      ack_drv = 1'b0;
      zw = 1'b1;
      key = 32'h0;

      // Streaming at one instruction per cycle.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 32'h0, 0);
         chk("t1_pc", instr_pc, 32'(i * 4));
      end

      // Fill and stall, then retire into a full buffer.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         advance = tv[i].adv;
         #1;
         chk("t2_req", 32'(imem_req), 32'(tv[i].req));
         if (tv[i].req) chk("t2_addr", imem_addr, tv[i].addr);
         @(posedge clk);
         @(negedge clk);
         chk("t2_vld", 32'(instr_valid), 32'(tv[i].vld));
         chk("t2_pc", instr_pc, tv[i].pc);
         chk("t2_instr", instr, tv[i].pc);
         chk("t2_p8", pc_plus8, tv[i].pc + 32'd8);
      end

      // Redirect against a pending request on a slow memory.
      do_reset();
      zw = 1'b0;
      seq_to_drop();
      chk("t3_hold", imem_addr, 32'h8);
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 1);
      chk("t3_addr", imem_addr, 32'h100);
      cycle(0, 0, 32'h0, 0);
      cycle(0, 0, 32'h0, 1);
      chk("t3_pc", instr_pc, 32'h100);
      chk("t3_vld", 32'(instr_valid), 32'h1);

      // Redirect coinciding with a zero-wait ack.
      do_reset();
      zw = 1'b1;
      cycle(0, 0, 32'h0, 0);
      cycle(1, 1, 32'h40, 0);
      chk("t4_empty", 32'(instr_valid), 32'h0);
      chk("t4_addr", imem_addr, 32'h40);
      cycle(0, 0, 32'h0, 0);
      chk("t4_pc", instr_pc, 32'h40);

      // Address wrap from the top of memory (second instance).
      do_reset();
      chk("t5_a0", addr2, 32'hFFFF_FFF8);
      cycle(0, 0, 32'h0, 0);
      chk("t5_a1", addr2, 32'hFFFF_FFFC);
      chk("t5_pc0", ipc2, 32'hFFFF_FFF8);
      cycle(0, 0, 32'h0, 0);
      chk("t5_a2", addr2, 32'h0);
      chk("t5_pc1", ipc2, 32'hFFFF_FFFC);
      chk("t5_instr1", instr2, 32'hFFFF_FFFC);
      chk("t5_p8", p8_2, 32'h4);
      chk("t5_vld", 32'(vld2), 32'h1);
      cycle(0, 0, 32'h0, 0);
      chk("t5_pc2", ipc2, 32'h0);
`ifdef FETCH_PERF_EN
      chk("t5_perf_f", perf_fetched2, 32'd3);
      chk("t5_perf_s", perf_stall2, 32'd1);
`endif

      // Asynchronous reset in the middle of a dropped request.
      do_reset();
      zw = 1'b0;
      seq_to_drop();
      cycle(0, 0, 32'h0, 0);
      #2 reset = 1'b1;
      #1 check_reset_vals("t6");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) cycle(i > 3, 0, 32'h0, i != 1);

      // Random traffic: slow memory, then zero-wait memory.
      key = $urandom;
      for (int i = 0; i < 1500; i++)
         cycle(($urandom % 4) != 0, ($urandom % 6) == 0, $urandom, ($urandom % 3) != 0);
      zw = 1'b1;
      for (int i = 0; i < 600; i++)
         cycle(($urandom % 4) != 0, ($urandom % 6) == 0, $urandom, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
